// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: shared state enum, default widths and axis
// timing bundle for the VGA timing generator.
package vga_timing_gen_pkg;

    localparam int TIMCNT_WIDTH_DEF = 12;
    localparam int DIV_WIDTH_DEF    = 8;

    typedef enum logic [1:0] {
        SYNC       = 2'd0,
        BACKPORCH  = 2'd1,
        VISIBLE    = 2'd2,
        FRONTPORCH = 2'd3
    } timfsm_e;

    typedef struct packed {
        logic [TIMCNT_WIDTH_DEF-1:0] bp;
        logic [TIMCNT_WIDTH_DEF-1:0] sn;
        logic [TIMCNT_WIDTH_DEF-1:0] fp;
        logic [TIMCNT_WIDTH_DEF-1:0] vlen;
    } vga_axis_cfg_t;

    function automatic timfsm_e next_state(input timfsm_e s);
        timfsm_e n;
        n = SYNC;
        unique case (s)
            SYNC:       n = BACKPORCH;
            BACKPORCH:  n = VISIBLE;
            VISIBLE:    n = FRONTPORCH;
            FRONTPORCH: n = SYNC;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// vga_timing_axis: one sync/backporch/visible/frontporch axis FSM with
// its in-state position counter; used for both H and V.
module vga_timing_axis
    import vga_timing_gen_pkg::*;
#(
    parameter int W = TIMCNT_WIDTH_DEF
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         adv_i,
    input  logic [W-1:0] vlen_i,
    input  logic [W-1:0] bp_i,
    input  logic [W-1:0] sn_i,
    input  logic [W-1:0] fp_i,
    output logic         sync_o,
    output logic         vis_o,
    output logic         last_o,
    output logic [W-1:0] cnt_o
);

    timfsm_e      state_q, state_d;
    logic [W-1:0] pos_q, pos_d;
    logic [W-1:0] len, lim;
    logic         at_end;

    always_comb begin
        len = sn_i;
        unique case (state_q)
            SYNC:       len = sn_i;
            BACKPORCH:  len = bp_i;
            VISIBLE:    len = vlen_i;
            FRONTPORCH: len = fp_i;
        endcase
    end

    // a zero field behaves as a one-unit field
    assign lim    = (len == '0) ? '0 : len - 1'b1;
    assign at_end = (pos_q == lim);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        if (clr_i) begin
            state_d = SYNC;
            pos_d   = '0;
        end else if (adv_i) begin
            if (at_end) begin
                state_d = next_state(state_q);
                pos_d   = '0;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= SYNC;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
        end
    end

    assign sync_o = (state_q == SYNC);
    assign vis_o  = (state_q == VISIBLE);
    assign last_o = adv_i & (state_q == FRONTPORCH) & at_end;
    assign cnt_o  = vis_o ? pos_q : '0;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA sync / data-enable timing generator.
// Define VGA_TIMING_GEN_DBUF_EN to add the swap_i / cfb_o frame-buffer flip.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int TIMCNT_WIDTH = TIMCNT_WIDTH_DEF,
    parameter int DIV_WIDTH    = DIV_WIDTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic [DIV_WIDTH-1:0]    div_i,
    input  logic [TIMCNT_WIDTH-1:0] hvlen_i,
    input  logic [TIMCNT_WIDTH-1:0] hbp_i,
    input  logic [TIMCNT_WIDTH-1:0] hsn_i,
    input  logic [TIMCNT_WIDTH-1:0] hfp_i,
    input  logic [TIMCNT_WIDTH-1:0] vvlen_i,
    input  logic [TIMCNT_WIDTH-1:0] vbp_i,
    input  logic [TIMCNT_WIDTH-1:0] vsn_i,
    input  logic [TIMCNT_WIDTH-1:0] vfp_i,
    input  logic                    hspol_i,
    input  logic                    vspol_i,
    input  logic                    blpol_i,
    output logic                    hsync_o,
    output logic                    vsync_o,
    output logic                    de_o,
    output logic                    pix_tick_o,
    output logic [TIMCNT_WIDTH-1:0] hcnt_o,
    output logic [TIMCNT_WIDTH-1:0] vcnt_o,
    output logic                    hend_o,
    output logic                    vend_o
`ifdef VGA_TIMING_GEN_DBUF_EN
    ,
    input  logic                    swap_i,
    output logic                    cfb_o
`endif
);

    logic                    en_q, run, tick, load;
    logic [DIV_WIDTH-1:0]    div_q, div_cnt;
    logic [TIMCNT_WIDTH-1:0] hv_q, hb_q, hs_q, hf_q;
    logic [TIMCNT_WIDTH-1:0] vv_q, vb_q, vs_q, vf_q;
    logic                    hpol_q, vpol_q, bpol_q;
    logic                    h_sync, h_vis, h_last;
    logic                    v_sync, v_vis, v_last;

    // run needs a settled shadow set, so it starts the clock after en_i rises
    assign run  = en_i & en_q;
    assign tick = run & (div_cnt == div_q);
    assign load = ~en_q | v_last;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_q    <= 1'b0;
            div_cnt <= '0;
        end else begin
            en_q <= en_i;
            if (!run || tick) div_cnt <= '0;
            else              div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q  <= '0;
            hv_q   <= '0;
            hb_q   <= '0;
            hs_q   <= '0;
            hf_q   <= '0;
            vv_q   <= '0;
            vb_q   <= '0;
            vs_q   <= '0;
            vf_q   <= '0;
            hpol_q <= 1'b0;
            vpol_q <= 1'b0;
            bpol_q <= 1'b0;
        end else if (load) begin
            div_q  <= div_i;
            hv_q   <= hvlen_i;
            hb_q   <= hbp_i;
            hs_q   <= hsn_i;
            hf_q   <= hfp_i;
            vv_q   <= vvlen_i;
            vb_q   <= vbp_i;
            vs_q   <= vsn_i;
            vf_q   <= vfp_i;
            hpol_q <= hspol_i;
            vpol_q <= vspol_i;
            bpol_q <= blpol_i;
        end
    end

    vga_timing_axis #(.W(TIMCNT_WIDTH)) u_h (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (~run),
        .adv_i   (tick),
        .vlen_i  (hv_q),
        .bp_i    (hb_q),
        .sn_i    (hs_q),
        .fp_i    (hf_q),
        .sync_o  (h_sync),
        .vis_o   (h_vis),
        .last_o  (h_last),
        .cnt_o   (hcnt_o)
    );

    vga_timing_axis #(.W(TIMCNT_WIDTH)) u_v (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (~run),
        .adv_i   (h_last),
        .vlen_i  (vv_q),
        .bp_i    (vb_q),
        .sn_i    (vs_q),
        .fp_i    (vf_q),
        .sync_o  (v_sync),
        .vis_o   (v_vis),
        .last_o  (v_last),
        .cnt_o   (vcnt_o)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            de_o    <= 1'b0;
        end else begin
            hsync_o <= (run & h_sync) ^ ~hpol_q;
            vsync_o <= (run & v_sync) ^ ~vpol_q;
            de_o    <= (run & h_vis & v_vis) ^ ~bpol_q;
        end
    end

    assign pix_tick_o = tick;
    assign hend_o     = h_last;
    assign vend_o     = v_last;

`ifdef VGA_TIMING_GEN_DBUF_EN
    logic pend_q;

    // a swap landing on the flipping vend re-arms for the following frame
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q <= 1'b0;
            cfb_o  <= 1'b0;
        end else if (v_last && pend_q) begin
            cfb_o  <= ~cfb_o;
            pend_q <= swap_i;
        end else if (swap_i) begin
            pend_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: frame-position model of the timing generator
// compared every cycle, plus hand-computed period and level checks.
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  div;
    logic [11:0] hv, hb, hs, hf, vv, vb, vs, vf;
    logic        hp, vp, bp;
    logic        hsync_o, vsync_o, de_o, pix_tick_o, hend_o, vend_o;
    logic [11:0] hcnt_o, vcnt_o;
`ifdef VGA_TIMING_GEN_DBUF_EN
    logic        swap;
    logic        cfb_o;
    logic        cfb0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .div_i      (div),
        .hvlen_i    (hv),
        .hbp_i      (hb),
        .hsn_i      (hs),
        .hfp_i      (hf),
        .vvlen_i    (vv),
        .vbp_i      (vb),
        .vsn_i      (vs),
        .vfp_i      (vf),
        .hspol_i    (hp),
        .vspol_i    (vp),
        .blpol_i    (bp),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o),
        .de_o       (de_o),
        .pix_tick_o (pix_tick_o),
        .hcnt_o     (hcnt_o),
        .vcnt_o     (vcnt_o),
        .hend_o     (hend_o),
        .vend_o     (vend_o)
`ifdef VGA_TIMING_GEN_DBUF_EN
        ,
        .swap_i     (swap),
        .cfb_o      (cfb_o)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: frame position (pixel p of line l) under the active settings
    vga_axis_cfg_t m_h, m_v;
    int  m_div = 0, m_divc = 0, m_p = 0, m_l = 0;
    bit  m_run = 0, m_hp = 0, m_vp = 0, m_bp = 0;
    bit  x_hs = 0, x_vs = 0, x_de = 0;

    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic int tot(input vga_axis_cfg_t c);
        return eff(int'(c.sn)) + eff(int'(c.bp)) + eff(int'(c.vlen)) + eff(int'(c.fp));
    endfunction

    // 0 sync, 1 back porch, 2 visible, 3 front porch
    function automatic int region(input vga_axis_cfg_t c, input int p);
        int a, b, v;
        a = eff(int'(c.sn));
        b = a + eff(int'(c.bp));
        v = b + eff(int'(c.vlen));
        if (p < a) return 0;
        if (p < b) return 1;
        if (p < v) return 2;
        return 3;
    endfunction

    function automatic int vidx(input vga_axis_cfg_t c, input int p);
        return (region(c, p) == 2) ? p - eff(int'(c.sn)) - eff(int'(c.bp)) : 0;
    endfunction

    function automatic bit m_tick();
        return en && m_run && (m_divc == m_div);
    endfunction

    function automatic bit m_hend();
        return m_tick() && (m_p == tot(m_h) - 1);
    endfunction

    function automatic bit m_vend();
        return m_hend() && (m_l == tot(m_v) - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        bit run, tk, vd;
        if (!rst_n) begin
            m_h = '0; m_v = '0;
            m_div = 0; m_divc = 0; m_p = 0; m_l = 0;
            m_run = 0; m_hp = 0; m_vp = 0; m_bp = 0;
            x_hs = 0; x_vs = 0; x_de = 0;
        end else begin
            run = en && m_run;
            tk  = m_tick();
            vd  = m_vend();
            x_hs = (run && region(m_h, m_p) == 0) ^ !m_hp;
            x_vs = (run && region(m_v, m_l) == 0) ^ !m_vp;
            x_de = (run && region(m_h, m_p) == 2 && region(m_v, m_l) == 2) ^ !m_bp;
            if (!run) begin
                m_divc = 0; m_p = 0; m_l = 0;
            end else if (tk) begin
                m_divc = 0;
                m_p++;
                if (m_p >= tot(m_h)) begin
                    m_p = 0;
                    m_l++;
                    if (m_l >= tot(m_v)) m_l = 0;
                end
            end else begin
                m_divc++;
            end
            if (!m_run || vd) begin
                m_div = int'(div);
                m_h = '{bp: hb, sn: hs, fp: hf, vlen: hv};
                m_v = '{bp: vb, sn: vs, fp: vf, vlen: vv};
                m_hp = hp; m_vp = vp; m_bp = bp;
            end
            m_run = en;
        end
    end

    always @(negedge clk) begin
        chk("hsync", int'(hsync_o), int'(x_hs));
        chk("vsync", int'(vsync_o), int'(x_vs));
        chk("de", int'(de_o), int'(x_de));
        chk("pix_tick", int'(pix_tick_o), int'(m_tick()));
        chk("hend", int'(hend_o), int'(m_hend()));
        chk("vend", int'(vend_o), int'(m_vend()));
        chk("hcnt", int'(hcnt_o), vidx(m_h, m_p));
        chk("vcnt", int'(vcnt_o), vidx(m_v, m_l));
    end

    function automatic bit sig(input int w);
        case (w)
            0:       return hend_o;
            1:       return vend_o;
            2:       return pix_tick_o;
            3:       return hsync_o;
            default: return de_o;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int d, input int h1, input int h2, input int h3,
                           input int h4, input int v1, input int v2, input int v3,
                           input int v4, input bit ph, input bit pv, input bit pb);
        div = 8'(d);
        hv = 12'(h1); hb = 12'(h2); hs = 12'(h3); hf = 12'(h4);
        vv = 12'(v1); vb = 12'(v2); vs = 12'(v3); vf = 12'(v4);
        hp = ph; vp = pv; bp = pb;
    endtask

    task automatic wait_pulse(input string nm, input int w);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(w) && n < 30000);
        if (!sig(w)) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic period(input string nm, input int w, input int exp);
        int n = 0;
        wait_pulse(nm, w);
        do begin
            @(negedge clk);
            n++;
        end while (!sig(w) && n < 30000);
        chk(nm, n, exp);
    endtask

    task automatic count_level(input string nm, input int w, input bit lvl,
                               input int win, input int exp);
        int n = 0;
        repeat (win) begin
            @(negedge clk);
            if (sig(w) == lvl) n++;
        end
        chk(nm, n, exp);
    endtask

    task automatic latency(input string nm, input int w, input int exp);
        int n = 0;
        en = 1'b1;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!sig(w) && n < 30000);
        chk(nm, n, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
`ifdef VGA_TIMING_GEN_DBUF_EN
        swap  = 1'b0;
`endif
        set_cfg(0, 4, 2, 1, 1, 3, 1, 1, 1, 1, 1, 1);
        #12;
        chk("rst_hsync", int'(hsync_o), 0);
        chk("rst_vsync", int'(vsync_o), 0);
        chk("rst_de", int'(de_o), 0);
        chk("rst_tick", int'(pix_tick_o), 0);
        chk("rst_hend", int'(hend_o), 0);
        chk("rst_hcnt", int'(hcnt_o), 0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("idle_hsync", int'(hsync_o), 0);

        latency("lat_div0", 2, 1);
        period("hend_div0", 0, 8);
        period("vend_div0", 1, 48);
        wait_pulse("v0", 1);
        count_level("de_frame", 4, 1'b1, 48, 12);

        step(1);
        en = 1'b0;
        div = 8'd1;
        step(2);
        latency("lat_div1", 2, 2);
        period("tick_div1", 2, 2);
        period("vend_div1", 1, 96);

        step(1);
        en = 1'b0;
        div = 8'd0;
        hp = 1'b0;
        bp = 1'b0;
        step(3);
        chk("idle_hsync_inv", int'(hsync_o), 1);
        chk("idle_de_inv", int'(de_o), 1);
        en = 1'b1;
        step(2);
        wait_pulse("h1", 0);
        count_level("hsync_low_line", 3, 1'b0, 8, 1);
        wait_pulse("v1", 1);
        count_level("de_low_frame", 4, 1'b0, 48, 12);

        step(1);
        en = 1'b0;
        hp = 1'b1;
        bp = 1'b1;
        step(2);
        en = 1'b1;
        wait_pulse("v2", 1);
        wait_pulse("h2", 0);
        step(1);
        hv = 12'd6;
        period("hend_keep", 0, 8);
        wait_pulse("v3", 1);
        period("hend_new", 0, 10);
        period("vend_new", 1, 60);

        step(1);
        hv = 12'd4; hb = 12'd0; hs = 12'd0; hf = 12'd0;
        wait_pulse("v4", 1);
        period("hend_zero", 0, 7);

        step(1);
        hv = 12'd4095; hb = 12'd1; hs = 12'd1; hf = 12'd1;
        wait_pulse("v5", 1);
        period("hend_max", 0, 4098);

        step(1);
        en = 1'b0;
        set_cfg(0, 4, 2, 1, 1, 3, 1, 1, 1, 1, 1, 1);
        step(2);
        en = 1'b1;
        wait_pulse("v6", 1);
        repeat (3) wait_pulse("h3", 0);
        step(5);
        chk("de_before_drop", int'(de_o), 1);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("drop_de", int'(de_o), 0);
        chk("drop_hsync", int'(hsync_o), 0);
        chk("drop_vsync", int'(vsync_o), 0);
        chk("drop_hcnt", int'(hcnt_o), 0);
        chk("drop_tick", int'(pix_tick_o), 0);
        step(2);
        latency("restart_hend", 0, 8);

`ifdef VGA_TIMING_GEN_DBUF_EN
        wait_pulse("v7", 1);
        step(5);
        cfb0 = cfb_o;
        swap = 1'b1;
        step(1);
        swap = 1'b0;
        step(3);
        swap = 1'b1;
        step(1);
        swap = 1'b0;
        chk("cfb_hold", int'(cfb_o), int'(cfb0));
        wait_pulse("v8", 1);
        @(negedge clk);
        chk("cfb_toggle", int'(cfb_o), int'(!cfb0));
        wait_pulse("v9", 1);
        @(negedge clk);
        chk("cfb_once", int'(cfb_o), int'(!cfb0));
`endif

        step(5);
        chk("tick_before_rst", int'(pix_tick_o), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tick", int'(pix_tick_o), 0);
        chk("arst_hcnt", int'(hcnt_o), 0);
        chk("arst_de", int'(de_o), 0);
        #20;
        rst_n = 1'b1;
        step(3);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter TIMCNT_WIDTH, default 12, SHALL set the width of all timing fields and counters.
REQ-002 Parameter DIV_WIDTH, default 8, SHALL set the pixel-divider width.
REQ-003 clk_i  input  1  SHALL be the single clock.
REQ-004 rst_n_i  input  1  SHALL be the asynchronous active-low reset.
REQ-005 en_i  input  1  SHALL enable timing generation.
REQ-006 div_i  input  DIV_WIDTH  SHALL set the pixel tick period to div_i+1 clocks.
REQ-007 hvlen_i, hbp_i, hsn_i, hfp_i  input  TIMCNT_WIDTH each  SHALL set the horizontal visible, back-porch, sync and front-porch lengths in pixels.
REQ-008 vvlen_i, vbp_i, vsn_i, vfp_i  input  TIMCNT_WIDTH each  SHALL set the vertical visible, back-porch, sync and front-porch lengths in lines.
REQ-009 hspol_i, vspol_i, blpol_i  input  1 each  SHALL give the sync and blank active levels (1 = active-high).
REQ-010 hsync_o, vsync_o, de_o  output  1 each  SHALL carry the polarity-applied sync and data-enable outputs.
REQ-011 pix_tick_o  output  1  SHALL pulse for one clock per pixel.
REQ-012 hcnt_o, vcnt_o  output  TIMCNT_WIDTH  SHALL give the pixel/line index within the visible region.
REQ-013 hend_o, vend_o  output  1 each  SHALL pulse for one clock at line end and at frame end.

Function
REQ-014 The divider SHALL count 0..div_i, and pix_tick_o SHALL assert on the clock where it equals div_i; div_i=0 SHALL tick every clock.
REQ-015 The H FSM SHALL cycle SYNC -> BACKPORCH -> VISIBLE -> FRONTPORCH -> SYNC, with each state lasting its field length in ticks.
REQ-016 A zero-length field SHALL be treated as length 1.
REQ-017 The V FSM SHALL use the same states and order, advancing one line count per hend_o.
REQ-018 hend_o SHALL pulse on the last tick of H FRONTPORCH, and vend_o SHALL pulse on the hend_o that ends V FRONTPORCH.
REQ-019 Sync SHALL be active only in the SYNC state of its own FSM.
REQ-020 de_o SHALL be active only when both FSMs are in VISIBLE.
REQ-021 Output level SHALL equal active ^ ~pol, i.e. inverted when pol=0.
REQ-022 hsync_o, vsync_o and de_o SHALL be registered, with one clock of latency from the FSM state.
REQ-023 hcnt_o/vcnt_o SHALL increment in VISIBLE from 0 and SHALL read 0 outside VISIBLE.
REQ-024 All timing and polarity inputs SHALL be captured into shadow registers on en_i rising and on each vend_o; mid-frame input changes SHALL NOT affect the current frame.
REQ-025 en_i low SHALL synchronously clear the divider and counters and force both FSMs to SYNC; syncs and de_o SHALL then be held at their inactive level.
REQ-026 On en_i rising, the first pix_tick_o SHALL follow div_i+1 clocks later.
REQ-027 Counter arithmetic SHALL be unsigned TIMCNT_WIDTH, with no wrap inside a state; field value 2^TIMCNT_WIDTH-1 SHALL be the maximum length.

Reset
REQ-028 On rst_n_i low, all state SHALL clear: FSMs = SYNC, counters = 0, pix_tick_o/hend_o/vend_o = 0, hsync_o = vsync_o = de_o = 0, shadows = 0.
REQ-029 Reset assertion mid-frame SHALL take effect immediately regardless of clk_i.

Configuration
REQ-030 With VGA_TIMING_GEN_DBUF_EN defined, output cfb_o (1 bit, reset 0) SHALL exist, and input swap_i SHALL set a pending flag.
REQ-031 With VGA_TIMING_GEN_DBUF_EN defined, cfb_o SHALL toggle on the vend_o following a pending swap, which clears the flag; swap_i coincident with vend_o SHALL apply at the next vend_o.
REQ-032 Without VGA_TIMING_GEN_DBUF_EN, cfb_o, swap_i and the pending logic SHALL be absent.

Structure
REQ-033 The shared vga package SHALL hold the TIMFSM state enum (width 2), the default TIMCNT_WIDTH and DIV_WIDTH, and a struct bundling bp/sn/fp/vlen fields.
REQ-034 One sub-module, vga_timing_axis, SHALL implement one axis FSM plus counter, instanced twice (H advanced by pix_tick, V by hend).

Verification
REQ-035 div=0, H vis4/bp2/sn1/fp1, V vis3/bp1/sn1/fp1, all pol=1 -> hend_o every 8 clocks, vend_o every 48 clocks, 12 de_o clocks per frame.
REQ-036 Same timing with div=1 -> pix_tick_o every 2 clocks and vend_o period 96 clocks.
REQ-037 hspol=0, blpol=0 -> hsync_o low for 1 pixel per line and de_o low during visible; idle levels inverted.
REQ-038 hvlen changed 4 -> 6 mid-frame -> current frame keeps the 8-clock line; lines become 10 clocks after the next vend_o.
REQ-039 en_i dropped mid-line then restored -> outputs inactive within 1 clock; restart from SYNC with counters at 0.
REQ-040 With DBUF_EN defined, swap_i pulsed twice in one frame -> cfb_o toggles exactly once, at the next vend_o.
